// File: rtl/axi_ready_gen_multi.sv
// axi_ready_gen_multi: per-channel programmable AXI READY generator (NOBP/OSC/SINGLE/RANDOM) with stall watchdog
module axi_ready_gen_multi #(
    parameter int NUM_CH    = 5,
    parameter int CNT_W     = 8,
    parameter int MAX_STALL = 64,
    parameter int HS_CNT_W  = 16
) (
    input  logic                                         aclk,
    input  logic                                         aresetn,
    input  logic                                         cfg_wr,
    input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [1:0]                                   cfg_mode,
    input  logic [CNT_W-1:0]                             cfg_low,
    input  logic [CNT_W-1:0]                             cfg_high,
    input  logic [15:0]                                  cfg_seed,
    input  logic [NUM_CH-1:0]                            valid_i,
    output logic [NUM_CH-1:0]                            ready_o,
    output logic [NUM_CH*HS_CNT_W-1:0]                   hs_cnt_o,
    output logic [NUM_CH-1:0]                            stall_flag_o
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ASSERT} single_t;
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int ST_W = MAX_STALL > 1 ? $clog2(MAX_STALL) : 1;
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(MAX_STALL - 1);
    localparam logic [15:0] SEED_DEF = 16'hACE1;
    localparam logic [1:0] M_NOBP = 2'd0, M_OSC = 2'd1, M_SINGLE = 2'd2, M_RANDOM = 2'd3;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [1:0]          r_mode;
        logic [CNT_W-1:0]    r_low, r_high, r_cnt, w_cnt, w_len;
        logic [15:0]         r_lfsr, w_lfsr;
        logic [ST_W-1:0]     r_stall, w_stall;
        logic [HS_CNT_W-1:0] r_hs;
        logic                r_ph, w_ph, r_ready, r_flag, w_ready, w_hs, w_stalled, w_force, w_cfg, w_wrap;
        single_t             r_st, w_st;
        assign w_hs      = valid_i[c] && r_ready;
        assign w_cfg     = cfg_wr && cfg_ch == CH_W'(c);
        assign w_stalled = valid_i[c] && !r_ready;
        assign w_force   = MAX_STALL > 0 && w_stalled && r_stall == ST_LAST;
        assign w_len     = r_ph ? r_high : r_low;
        assign w_wrap    = r_cnt >= w_len - CNT_W'(1);
        assign ready_o[c]                         = r_ready;
        assign stall_flag_o[c]                    = r_flag;
        assign hs_cnt_o[c*HS_CNT_W +: HS_CNT_W]   = r_hs;
        always_comb begin
            w_lfsr  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
            w_ph    = r_ph;
            w_cnt   = r_cnt;
            w_st    = r_st;
            w_ready = 1'b1;
            w_stall = (w_stalled && !w_force) ? r_stall + ST_W'(1) : '0;
            case (r_mode)
                M_OSC: begin
                    w_ready = r_low == '0 || (r_ph && r_high != '0);
                    w_ph    = w_wrap ? !r_ph : r_ph;
                    w_cnt   = w_wrap ? '0 : r_cnt + CNT_W'(1);
                end
                M_SINGLE: begin
                    w_ready = 1'b0;
                    case (r_st)
                        S_IDLE: if (valid_i[c]) begin
                            w_st    = r_low == '0 ? S_ASSERT : S_WAIT;
                            w_cnt   = r_low;
                            w_ready = r_low == '0;
                        end
                        S_WAIT: begin
                            w_cnt   = r_cnt - CNT_W'(1);
                            w_st    = r_cnt <= CNT_W'(1) ? S_ASSERT : S_WAIT;
                            w_ready = r_cnt <= CNT_W'(1);
                        end
                        default: begin
                            w_st    = w_hs ? S_IDLE : S_ASSERT;
                            w_ready = !w_hs;
                        end
                    endcase
                end
                M_RANDOM: w_ready = r_lfsr[CNT_W-1:0] >= r_low;
                default: ;
            endcase
            // SINGLE keeps a forced READY up until the handshake lands
            if (w_force) begin
                w_ready = 1'b1;
                w_st    = r_mode == M_SINGLE ? S_ASSERT : w_st;
            end
        end
        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                r_mode  <= M_NOBP;
                r_low   <= '0;
                r_high  <= '0;
                r_lfsr  <= SEED_DEF;
                r_cnt   <= '0;
                r_ph    <= 1'b0;
                r_st    <= S_IDLE;
                r_stall <= '0;
                r_ready <= 1'b0;
                r_flag  <= 1'b0;
                r_hs    <= '0;
            end else begin
                r_ready <= w_ready;
                r_hs    <= w_hs ? r_hs + HS_CNT_W'(1) : r_hs;
                r_flag  <= r_flag || w_force;
                if (w_cfg) begin
                    r_mode  <= cfg_mode;
                    r_low   <= cfg_low;
                    r_high  <= cfg_high;
                    r_lfsr  <= cfg_seed == '0 ? SEED_DEF : cfg_seed;
                    r_cnt   <= '0;
                    r_ph    <= 1'b0;
                    r_st    <= S_IDLE;
                    r_stall <= '0;
                end else begin
                    r_lfsr  <= w_lfsr;
                    r_cnt   <= w_cnt;
                    r_ph    <= w_ph;
                    r_st    <= w_st;
                    r_stall <= w_stall;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_ready_gen_multi.sv
// tb_axi_ready_gen_multi: directed self-checking bench for axi_ready_gen_multi
module tb_axi_ready_gen_multi;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [2:0]  cfg_ch = '0;
    logic [1:0]  cfg_mode = '0;
    logic [7:0]  cfg_low = '0;
    logic [7:0]  cfg_high = '0;
    logic [15:0] cfg_seed = '0;
    logic [4:0]  valid_i = '0;
    logic [4:0]  ready_o;
    logic [79:0] hs_cnt_o;
    logic [4:0]  stall_flag_o;
    int checks = 0;
    int errors = 0;

    axi_ready_gen_multi dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_low(cfg_low), .cfg_high(cfg_high), .cfg_seed(cfg_seed),
        .valid_i(valid_i), .ready_o(ready_o), .hs_cnt_o(hs_cnt_o), .stall_flag_o(stall_flag_o)
    );

    always #5 aclk = ~aclk;

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [2:0] ch, input logic [1:0] mode, input logic [7:0] lo,
                       input logic [7:0] hi, input logic [15:0] seed);
        cfg_wr = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_low = lo; cfg_high = hi; cfg_seed = seed;
        tick();
        cfg_wr = 1'b0;
    endtask

    function automatic logic [15:0] hs(input int c);
        return hs_cnt_o[c*16 +: 16];
    endfunction

    function automatic logic [15:0] nx(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    initial begin
        logic [15:0] m;
        logic exp, cur, force_w;
        int k, st, ones;
        tick(); tick();
        chk("rst_ready", ready_o, 5'b00000);
        chk("rst_hs", hs_cnt_o, 80'h0);
        chk("rst_flag", stall_flag_o, 5'b00000);
        aresetn = 1'b1;
        tick();
        chk("nobp_first", ready_o, 5'b11111);
        valid_i[0] = 1'b1;
        repeat (10) tick();
        valid_i[0] = 1'b0;
        chk("nobp_hs0", hs(0), 16'd10);
        chk("nobp_hs_other", hs(1), 16'd0);

        cfg(3'd1, 2'd1, 8'd3, 8'd2, 16'h0);
        tick();
        valid_i[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("osc_pat", ready_o[1], (i % 5) >= 3);
            tick();
        end
        valid_i[1] = 1'b0;
        chk("osc_hs1", hs(1), 16'd8);

        cfg(3'd2, 2'd2, 8'd4, 8'd0, 16'h0);
        tick();
        chk("single_idle", ready_o[2], 1'b0);
        for (int t = 0; t < 3; t++) begin
            valid_i[2] = 1'b1;
            k = 0;
            do begin
                tick();
                k++;
            end while (!ready_o[2] && k < 20);
            chk("single_lat", k, 5);
            tick();
            chk("single_drop", ready_o[2], 1'b0);
            valid_i[2] = 1'b0;
            tick();
        end
        chk("single_hs2", hs(2), 16'd3);

        cfg(3'd3, 2'd3, 8'd128, 8'd0, 16'h0001);
        m = 16'h0001;
        tick();
        exp = m[7:0] >= 8'd128;
        m = nx(m);
        chk("rnd_first", ready_o[3], exp);
        valid_i[3] = 1'b1;
        st = 0;
        ones = 0;
        for (int i = 0; i < 1000; i++) begin
            cur = exp;
            force_w = !cur && st == 63;
            st = (!cur && !force_w) ? st + 1 : 0;
            tick();
            exp = (m[7:0] >= 8'd128) || force_w;
            m = nx(m);
            chk("rnd_seq", ready_o[3], exp);
            ones += int'(ready_o[3]);
        end
        chk("rnd_duty", (ones >= 400 && ones <= 600), 1'b1);
        valid_i[3] = 1'b0;
        cfg(3'd3, 2'd3, 8'd128, 8'd0, 16'h0000);
        m = 16'hACE1;
        for (int i = 0; i < 50; i++) begin
            tick();
            exp = m[7:0] >= 8'd128;
            m = nx(m);
            chk("rnd_seed0", ready_o[3], exp);
        end

        cfg(3'd4, 2'd1, 8'd200, 8'd0, 16'h0);
        tick();
        valid_i[4] = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            chk("wd_low", ready_o[4], 1'b0);
            tick();
        end
        chk("wd_forced", ready_o[4], 1'b1);
        chk("wd_flag", stall_flag_o, 5'b10000);
        tick();
        chk("wd_release", ready_o[4], 1'b0);
        chk("wd_flag_sticky", stall_flag_o, 5'b10000);
        chk("wd_hs4", hs(4), 16'd1);
        valid_i[4] = 1'b0;

        valid_i[0] = 1'b1;
        cfg(3'd0, 2'd3, 8'd200, 8'd0, 16'h0005);
        valid_i[0] = 1'b0;
        tick();
        chk("recfg_ready0", ready_o[0], 1'b0);
        chk("recfg_hs0", hs(0), 16'd11);

        valid_i = 5'b11111;
        aresetn = 1'b0;
        tick();
        chk("midrst_ready", ready_o, 5'b00000);
        chk("midrst_hs", hs_cnt_o, 80'h0);
        chk("midrst_flag", stall_flag_o, 5'b00000);
        aresetn = 1'b1;
        valid_i = '0;
        tick();
        chk("post_rst_ready", ready_o, 5'b11111);
        cfg(3'd5, 2'd1, 8'd3, 8'd1, 16'h0);
        tick();
        chk("bad_ch_a", ready_o, 5'b11111);
        tick();
        chk("bad_ch_b", ready_o, 5'b11111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
